// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round-key buffer.
// Holds the round count, storage depth, FSM states and the round-key type.
package aes_pkg;

  localparam int NR     = 10;
  localparam int NUM_RK = 11;

  typedef logic [127:0] rk_t;
  typedef logic [3:0]   rk_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY,
    STREAM
  } state_t;

  // Map a stream step (0..10) onto a round number for the latched direction.
  function automatic rk_idx_t stream_idx(input logic rev, input rk_idx_t step);
    return rev ? (rk_idx_t'(NR) - step) : step;
  endfunction

endpackage

// File: rtl/aes_key_buf_128_if.sv
// Bundle of key-load, stream-request and streamed-key signals.
// The master side drives the expander words and requests; the buffer is the slave.
interface aes_key_buf_128_if import aes_pkg::*; ();

  logic        kld;
  logic [31:0] wo_0;
  logic [31:0] wo_1;
  logic [31:0] wo_2;
  logic [31:0] wo_3;
  logic        start;
  logic        dir;
  logic        ready;
  rk_t         rk;
  logic        rk_vld;
  rk_idx_t     rk_idx;
  logic        rk_last;

  modport master (
    output kld, wo_0, wo_1, wo_2, wo_3, start, dir,
    input  ready, rk, rk_vld, rk_idx, rk_last
  );

  modport slave (
    input  kld, wo_0, wo_1, wo_2, wo_3, start, dir,
    output ready, rk, rk_vld, rk_idx, rk_last
  );

endinterface

// File: rtl/aes_rk_store.sv
// 11 x 128-bit round-key register file: one write port, one combinational read port.
// Deliberately unreset; contents are only meaningful after a complete fill.
module aes_rk_store import aes_pkg::*; (
  input  logic    clk,
  input  logic    we,
  input  rk_idx_t waddr,
  input  rk_t     wdata,
  input  rk_idx_t raddr,
  output rk_t     rdata
);

  rk_t mem [NUM_RK];

  always_ff @(posedge clk) begin
    if (we && (waddr < rk_idx_t'(NUM_RK))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr < rk_idx_t'(NUM_RK)) ? mem[raddr] : '0;

endmodule

// File: rtl/aes_key_buf_128.sv
// Captures the 11 AES-128 round keys emitted by the key expander after kld and
// replays them on request in forward or reverse round order.
module aes_key_buf_128 import aes_pkg::*; (
  input logic               clk,
  input logic               rst,
  aes_key_buf_128_if.slave  bus
);

  state_t  state;
  rk_idx_t cnt;
  logic    rev;
  logic    we;
  rk_idx_t raddr;
  rk_t     rdata;

  // cnt is the fill address in FILL and the stream step in STREAM.
  assign we    = (state == FILL) && !bus.kld;
  assign raddr = stream_idx(rev, cnt);

  aes_rk_store u_store (
    .clk   (clk),
    .we    (we),
    .waddr (cnt),
    .wdata ({bus.wo_0, bus.wo_1, bus.wo_2, bus.wo_3}),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rev         <= 1'b0;
      bus.ready   <= 1'b0;
      bus.rk_vld  <= 1'b0;
      bus.rk_last <= 1'b0;
      bus.rk_idx  <= '0;
      bus.rk      <= '0;
    end else if (bus.kld) begin
      // A key load overrides everything, including a same-edge start.
      state      <= FILL;
      cnt        <= '0;
      bus.ready  <= 1'b0;
      bus.rk_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        FILL: begin
          cnt <= cnt + 4'd1;
          if (cnt == rk_idx_t'(NR)) begin
            state     <= READY;
            cnt       <= '0;
            bus.ready <= 1'b1;
          end
        end
        READY: begin
          if (bus.start) begin
            rev   <= bus.dir;
            cnt   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (cnt == rk_idx_t'(NUM_RK)) begin
            bus.rk_vld <= 1'b0;
            cnt        <= '0;
            state      <= READY;
          end else begin
            bus.rk      <= rdata;
            bus.rk_idx  <= raddr;
            bus.rk_vld  <= 1'b1;
            bus.rk_last <= (cnt == rk_idx_t'(NR));
            cnt         <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_key_buf_128.md
AES_KEY_BUF_128 -- requirements
Module: aes_key_buf_128

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: kld  input  1  key-load strobe, the same net that drives the key expander's kld.
REQ-004 SHALL provide: wo_0, wo_1, wo_2, wo_3  input  32 each  expander round-key words; {wo_0,wo_1,wo_2,wo_3} forms the 128-bit round key.
REQ-005 SHALL provide: start  input  1  stream request, single-cycle pulse.
REQ-006 SHALL provide: dir  input  1  stream order, sampled with start: 0 = rounds 0..10, 1 = rounds 10..0.
REQ-007 SHALL provide: ready  output  1  all 11 round keys captured and valid.
REQ-008 SHALL provide: rk  output  128  streamed round key, registered.
REQ-009 SHALL provide: rk_vld  output  1  rk is valid this cycle.
REQ-010 SHALL provide: rk_idx  output  4  round number of rk (0..10).
REQ-011 SHALL provide: rk_last  output  1  final key of the stream.

Function
REQ-012 SHALL implement FSM states IDLE, FILL, READY, STREAM.
REQ-013 On a posedge with kld=1, from any state: enter FILL, fill counter = 0, ready = 0, rk_vld = 0, any stream aborted.
REQ-014 FILL: each posedge with kld=0 writes {wo_0..wo_3} into entry[counter] and increments the counter; the edge that writes entry 10 moves to READY.
- Entry r therefore holds round r; the full fill spans kld edge + 11 edges.
REQ-015 ready SHALL be 1 in READY and STREAM, otherwise 0.
REQ-016 In READY, start=1 SHALL latch dir and enter STREAM.
- First rk_vld appears on the following edge (1-cycle latency).
- rk_vld stays high for exactly 11 consecutive cycles.
REQ-017 Stream order: rk_idx steps 0..10 when dir=0, 10..0 when dir=1; rk = entry[rk_idx].
REQ-018 rk_last SHALL be 1 only with the 11th valid key; the next edge returns to READY with rk_vld = 0.
REQ-019 start SHALL be ignored in IDLE, FILL and STREAM; no queuing.
REQ-020 kld and start on the same edge: kld wins and start is dropped.
REQ-021 Stored keys SHALL persist in READY; any number of streams may be replayed without reloading.
REQ-022 rk, rk_idx and rk_last SHALL hold their last values when rk_vld = 0; only rk_vld qualifies them.

Reset
REQ-023 rst=1 SHALL immediately force: state IDLE, counter 0, ready 0, rk_vld 0, rk_last 0, rk_idx 0, rk 0.
REQ-024 Key storage SHALL NOT be reset; it is invalid until a complete FILL.
REQ-025 Reset during FILL or STREAM SHALL abandon the operation; ready stays 0 until a new kld and a full fill.

Structure
REQ-026 Shared package aes_pkg SHALL hold NR=10, NUM_RK=11, the state enum type and the 128-bit round-key typedef.
REQ-027 Storage SHALL be a sub-module aes_rk_store: an 11x128 register file with one write port and one read port, no reset.

Verification
REQ-028 kld with key 000102030405060708090a0b0c0d0e0f, 11 edges, start dir=0 -> idx0 rk=000102030405060708090a0b0c0d0e0f; idx10 rk=13111d7fe3944a17f307a78b4d2b30c5 with rk_last=1.
REQ-029 Key 2b7e151628aed2a6abf7158809cf4f3c, start dir=1 -> first rk=d014f9a8c9ee2589e13f0cc8b6630ca6 (idx10); idx1 rk=a0fafe1788542cb123a339392a6c7605; last rk = key.
REQ-030 kld, 5 edges, then kld again with the 2b7e key -> ready stays 0 until 11 edges after the second kld; stored data matches REQ-029.
REQ-031 kld asserted on the 4th cycle of a stream -> rk_vld drops on the next edge and ready = 0; start pulses during FILL produce no rk_vld.
REQ-032 Alternating all-ones / all-zeros key loads every 2 cycles -> ready never asserts; rst mid-FILL -> all outputs 0 asynchronously.
REQ-033 Two back-to-back streams (dir=0 then dir=1) from one fill -> 11 valid keys each, in the correct order, with identical data.
